// File: rtl/main_mem_responder.sv
// Burst main-memory responder: one read or write burst at a time against an internal word array.
// Out-of-range bursts complete their handshake, raise a one-cycle error and never touch the array.
module main_mem_responder #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int MEM_DEPTH         = 1024,
    parameter int FIXED_BURST_WRITE = 4,
    parameter int FIXED_BURST_READ  = 4,
    parameter int BURST_WIDTH       = 3
) (
    input  logic                  w_clock,
    input  logic                  w_rst_n,
    input  logic                  w_req_valid,
    output logic                  w_req_ready,
    input  logic                  w_main_mem_rw,
    input  logic [ADDR_WIDTH-1:0] w_main_mem_addr,
    input  logic [DATA_WIDTH-1:0] w_wdata,
    input  logic                  w_wvalid,
    output logic                  w_wready,
    output logic [DATA_WIDTH-1:0] w_rdata,
    output logic                  w_rvalid,
    input  logic                  w_rready,
    output logic                  w_rlast,
    output logic                  w_err
);

    // state   | meaning
    // S_IDLE  | ready for a request
    // S_WR    | consuming write beats
    // S_RD    | presenting read beats
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [BURST_WIDTH-1:0] WR_LAST = BURST_WIDTH'(FIXED_BURST_WRITE - 1);
    localparam logic [BURST_WIDTH-1:0] RD_LAST = BURST_WIDTH'(FIXED_BURST_READ - 1);
    localparam logic [ADDR_WIDTH:0]    DEPTH_X = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                  state_q;
    logic [IDX_W-1:0]        base_q;
    logic [BURST_WIDTH-1:0]  cnt_q;
    logic                    oor_q;
    logic                    req_ready_q;
    logic                    wready_q;
    logic                    rvalid_q;
    logic                    rlast_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [ADDR_WIDTH:0]     req_end;
    logic                    req_oor;
    logic [IDX_W-1:0]        req_idx;
    logic [IDX_W-1:0]        wr_idx;
    logic [BURST_WIDTH-1:0]  cnt_inc;
    logic [IDX_W-1:0]        rd_next_idx;
    logic                    wr_beat;

    // End address is computed one bit wider than the address so a burst near the top never wraps.
    assign req_end     = {1'b0, w_main_mem_addr}
                       + (ADDR_WIDTH+1)'(w_main_mem_rw ? FIXED_BURST_WRITE - 1 : FIXED_BURST_READ - 1);
    assign req_oor     = (req_end >= DEPTH_X);
    assign req_idx     = w_main_mem_addr[IDX_W-1:0];
    assign cnt_inc     = cnt_q + BURST_WIDTH'(1);
    assign wr_idx      = base_q + IDX_W'(cnt_q);
    assign rd_next_idx = base_q + IDX_W'(cnt_inc);
    assign wr_beat     = (state_q == S_WR) && w_wvalid;

    // Array has no reset: contents survive a reset pulse.
    always_ff @(posedge w_clock) begin
        if (wr_beat && !oor_q) begin
            mem[wr_idx] <= w_wdata;
        end
    end

    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            oor_q       <= 1'b0;
            req_ready_q <= 1'b0;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_req_valid && req_ready_q) begin
                        base_q      <= req_idx;
                        cnt_q       <= '0;
                        oor_q       <= req_oor;
                        err_q       <= req_oor;
                        req_ready_q <= 1'b0;
                        if (w_main_mem_rw) begin
                            state_q  <= S_WR;
                            wready_q <= 1'b1;
                        end else begin
                            state_q  <= S_RD;
                            rvalid_q <= 1'b1;
                            rdata_q  <= req_oor ? '0 : mem[req_idx];
                            rlast_q  <= (RD_LAST == '0);
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_WR: begin
                    if (w_wvalid) begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == WR_LAST) begin
                            state_q     <= S_IDLE;
                            wready_q    <= 1'b0;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    // Next word is fetched on the handshake edge; a stall holds data and rlast.
                    if (w_rready) begin
                        if (cnt_q == RD_LAST) begin
                            state_q     <= S_IDLE;
                            rvalid_q    <= 1'b0;
                            rlast_q     <= 1'b0;
                            rdata_q     <= '0;
                            req_ready_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_inc;
                            rdata_q <= oor_q ? '0 : mem[rd_next_idx];
                            rlast_q <= (cnt_inc == RD_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_req_ready = req_ready_q;
    assign w_wready    = wready_q;
    assign w_rvalid    = rvalid_q;
    assign w_rlast     = rlast_q;
    assign w_err       = err_q;
    assign w_rdata     = rdata_q;

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Main-memory-side responder for the burst request interface driven by the core's arbiter. It accepts one read or write request at a time and stores data in an internal word array. Writes take a fixed number of data beats and reads return a fixed number of data beats, with valid/ready flow control on every beat. It serves as the behavioural and synthesizable main memory for output-stationary core integration and is also the protocol checker for the arbiter's bursts.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of request address (word-addressed)
- DATA_WIDTH, 8, bits per data beat / memory word
- MEM_DEPTH, 1024, number of words in the array (≤ 2^ADDR_WIDTH)
- FIXED_BURST_WRITE, 4, beats per write burst (≥1)
- FIXED_BURST_READ, 4, beats per read burst (≥1)
- BURST_WIDTH, 3, beat-counter width; must hold max(FIXED_BURST_WRITE, FIXED_BURST_READ)

Ports (one clock; reset is asynchronous and active-low):
- w_clock  in  1  clock for all state
- w_rst_n  in  1  asynchronous active-low reset
- w_req_valid  in  1  request valid
- w_req_ready  out  1  request accepted when valid & ready
- w_main_mem_rw  in  1  1 = write, 0 = read; sampled on accept
- w_main_mem_addr  in  ADDR_WIDTH  burst base address; sampled on accept
- w_wdata  in  DATA_WIDTH  write beat data
- w_wvalid  in  1  write beat valid
- w_wready  out  1  write beat ready
- w_rdata  out  DATA_WIDTH  read beat data
- w_rvalid  out  1  read beat valid
- w_rready  in  1  read beat ready
- w_rlast  out  1  high with the final read beat
- w_err  out  1  one-cycle pulse: accepted burst out of range

## Operation
- FSM states: IDLE, WR, RD. Reset → IDLE.
- IDLE: w_req_ready=1. On accept, latch base address and rw, clear beat counter, and compute out_of_range = (base + burst_len − 1 ≥ MEM_DEPTH), evaluated at ADDR_WIDTH+1 bits so there is no wrap. Then go to WR if rw=1, otherwise RD.
- WR: w_wready=1. Each wvalid&wready beat writes mem[base+cnt] and increments cnt. When the beat with cnt = FIXED_BURST_WRITE−1 transfers, go to IDLE. Gaps in w_wvalid are allowed.
- RD: beat i is mem[base+i]. w_rlast=1 when i = FIXED_BURST_READ−1. When that beat's rvalid&rready handshake occurs, go to IDLE.
- Out-of-range burst: w_err pulses on the accept cycle and the burst still completes its full handshake. Write beats are consumed and discarded; no array word changes. Read beats return all zeros, and w_rlast behaves normally.
- No address wrap-around within a burst.
- w_req_ready=0 outside IDLE. A w_req_valid asserted during a burst waits.
- w_wready=0 outside WR. w_rvalid=0 outside RD. Write beats presented outside WR are ignored.
- Array contents are not cleared by reset. Reset mid-burst abandons the burst: state returns to IDLE, counters clear, and no further writes occur. Words already written keep their values.

## Timing
- Reset values while w_rst_n=0: w_req_ready=0, w_wready=0, w_rvalid=0, w_rlast=0, w_err=0, w_rdata=0. w_req_ready becomes 1 on the first cycle after deassertion.
- Request accept happens on edge T. w_wready is high in cycle T+1 (WR entry).
- Write beat: a beat transferred at edge E is visible to a read issued at any later request.
- Read latency: w_rdata is registered. The first beat has w_rvalid=1 in cycle T+1 after accept edge T.
- Read throughput is one beat per cycle while w_rready=1. The next word is fetched on each handshake edge.
- Backpressure: while w_rvalid & !w_rready, w_rdata and w_rlast hold stable.
- After the last write or read beat transfers at edge E, w_req_ready=1 in cycle E+1. Minimum request-to-request spacing is therefore burst_len+1 cycles.
- w_err is high exactly for cycle T+1 after accept edge T.

## Test plan
- Write burst to addr 0x10 with data 0xA1,0xA2,0xA3,0xA4 (defaults), then read burst at 0x10 → rdata 0xA1..0xA4 on 4 consecutive cycles, w_rlast only on 0xA4, w_err never asserted.
- Read at 0x10 with w_rready toggling 1,0,0,1,1,0,1 → each beat is held stable while stalled, 4 beats in order, and w_req_ready returns one cycle after the last handshake.
- Write at addr 1022 (MEM_DEPTH=1024) → w_err pulse at T+1, 4 beats accepted, mem[1022..1023] unchanged. A read at 1021 then returns 4 zero beats with w_err.
- Write burst with w_wvalid gaps (beats on cycles 1,3,4,7) → 4 words written correctly, FSM returns to IDLE after the 4th beat only.
- Assert w_rst_n=0 after 2 of 4 beats of a read → all outputs go to 0 immediately. After release, w_req_ready=1 and a new read returns the correct stored data.
- Back-to-back write (0x20) then read (0x20) with w_req_valid held high → the second request is accepted exactly one cycle after the write's last beat and returns the just-written data.
